ma_csub: RTL and testbench

- Final conditional-subtraction stage placed directly downstream of the 1040-bit Montgomery multiplier `ma`.
- Takes the multiplier's 1041-bit output C (bounded C < 2P) and modulus P, and produces R = (C >= P) ? C - P : C, fully reduced into [0, P).
- Works digit-serially, one 65-bit digit per cycle with a registered borrow chain, to match the multiplier's digit datapath and avoid a 1041-bit carry chain.
- Its start is driven from the multiplier's ready rising edge.

---
 rtl/ma_csub.sv | 116 +++++++++++
 tb/tb_ma_csub.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ma_csub.sv
// Digit-serial conditional subtraction R = (C >= P) ? C - P : C.
// Sits after the Montgomery multiplier; one 65-bit digit per cycle.
module ma_csub #(
    parameter int DIGIT_W = 65,
    parameter int NDIGITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DIGIT_W*NDIGITS:0]     inC,
    input  logic [DIGIT_W*NDIGITS-1:0]   inP,
    output logic [DIGIT_W*NDIGITS-1:0]   outR,
    output logic                         sub,
    output logic                         ready
);

    localparam int N  = DIGIT_W * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        SEL,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            borrow;
    logic [N:0]      reg_c;
    logic [N-1:0]    reg_p;
    logic [N-1:0]    reg_d;
    logic [N-1:0]    result;
    logic            sub_q;
    logic            ready_q;

    logic [DIGIT_W-1:0] c_dig;
    logic [DIGIT_W-1:0] p_dig;
    logic [DIGIT_W:0]   diff;
    logic               last;
    logic               ge;

    assign c_dig = reg_c[count*DIGIT_W +: DIGIT_W];
    assign p_dig = reg_p[count*DIGIT_W +: DIGIT_W];
    assign diff  = {1'b0, c_dig} - {1'b0, p_dig}
                 - {{DIGIT_W{1'b0}}, borrow};
    assign last  = (count == CW'(NDIGITS - 1));

    // Bit N of C absorbs the borrow out of the top digit.
    assign ge = reg_c[N] | ~borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        if (start) begin
            state_n = SUB;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE: ;
                SUB: begin
                    if (last) begin
                        state_n = SEL;
                        count_n = '0;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
                SEL:  state_n = DONE;
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_c   <= '0;
            reg_p   <= '0;
            reg_d   <= '0;
            borrow  <= 1'b0;
            result  <= '0;
            sub_q   <= 1'b0;
            ready_q <= 1'b0;
        end else if (start) begin
            reg_c   <= inC;
            reg_p   <= inP;
            reg_d   <= '0;
            borrow  <= 1'b0;
            ready_q <= 1'b0;
        end else if (state == SUB) begin
            reg_d[count*DIGIT_W +: DIGIT_W] <= diff[DIGIT_W-1:0];
            borrow <= diff[DIGIT_W];
        end else if (state == SEL) begin
            result  <= ge ? reg_d : reg_c[N-1:0];
            sub_q   <= ge;
            ready_q <= 1'b1;
        end
    end

    assign ready = ready_q;
    assign sub   = ready_q & sub_q;
    assign outR  = ready_q ? result : '0;

endmodule

// File: tb/tb_ma_csub.sv
// Directed bench for ma_csub: vector table plus restart/reset sequences.
module tb_ma_csub;

    localparam int N = 1040;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N:0]   inC;
    logic [N-1:0] inP;
    logic [N-1:0] outR;
    logic         sub;
    logic         ready;

    int n_vec;
    int n_err;

    typedef struct {
        logic [N:0]   c;
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic         s;
    } vec_t;

    vec_t tv[8];

    ma_csub #(.DIGIT_W(65), .NDIGITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inC   (inC),
        .inP   (inP),
        .outR  (outR),
        .sub   (sub),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_w(input string nm, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic do_start(input logic [N:0] c, input logic [N-1:0] p);
        @(negedge clk);
        inC   = c;
        inP   = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        inC   = '1;
        inP   = '1;
    endtask

    // Returns the edge count after the start edge at which ready rose.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        logic [N:0]   onec;
        logic [N-1:0] onen;
        int           cyc;
        int           seen;

        n_vec = 0;
        n_err = 0;
        onec  = 1;
        onen  = 1;
        rst_n = 1'b0;
        start = 1'b0;
        inC   = '0;
        inP   = '0;

        tv[0].c = (onec << 1039) | onec;
        tv[0].p = (onen << 1039) | onen;
        tv[0].r = '0;
        tv[0].s = 1'b1;

        tv[1].c = (onec << 1039) + 4;
        tv[1].p = (onen << 1039) + 5;
        tv[1].r = (onen << 1039) + 4;
        tv[1].s = 1'b0;

        tv[2].c = '1;
        tv[2].c = tv[2].c - 2;
        tv[2].p = '1;
        tv[2].r = '1;
        tv[2].r = tv[2].r - 1;
        tv[2].s = 1'b1;

        tv[3].c = onec << 64;
        tv[3].p = 1;
        tv[3].r = (onen << 64) - 1;
        tv[3].s = 1'b1;

        tv[4].c = 5;
        tv[4].p = 7;
        tv[4].r = 5;
        tv[4].s = 1'b0;

        tv[5].c = 0;
        tv[5].p = 1;
        tv[5].r = 0;
        tv[5].s = 1'b0;

        tv[6].c = onec << 65;
        tv[6].p = 3;
        tv[6].r = (onen << 65) - 3;
        tv[6].s = 1'b1;

        tv[7].c = (onec << 1040) + 10;
        tv[7].p = 3;
        tv[7].r = 7;
        tv[7].s = 1'b1;

        #12;
        chk_i("reset_ready", int'(ready), 0);
        chk_w("reset_outR", outR, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_i("idle_ready", int'(ready), 0);
        chk_w("idle_outR", outR, '0);

        foreach (tv[k]) begin
            do_start(tv[k].c, tv[k].p);
            chk_i($sformatf("v%0d_busy_ready", k), int'(ready), 0);
            chk_w($sformatf("v%0d_busy_outR", k), outR, '0);
            wait_ready(cyc);
            chk_i($sformatf("v%0d_latency", k), cyc, 17);
            chk_w($sformatf("v%0d_outR", k), outR, tv[k].r);
            chk_i($sformatf("v%0d_sub", k), int'(sub), int'(tv[k].s));
            repeat (3) @(posedge clk);
            #1;
            chk_w($sformatf("v%0d_hold", k), outR, tv[k].r);
        end

        // Start while DONE: ready must drop on the start edge.
        do_start(tv[0].c, tv[0].p);
        chk_i("done_restart_ready", int'(ready), 0);
        chk_i("done_restart_sub", int'(sub), 0);

        // Mid-operation restart at cycle 8.
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1;
        end
        do_start(5, 7);
        chk_i("restart_no_pulse", seen, 0);
        wait_ready(cyc);
        chk_i("restart_latency", cyc, 17);
        chk_w("restart_outR", outR, 5);
        chk_i("restart_sub", int'(sub), 0);

        // Asynchronous reset while results are shown.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("arst_done_ready", int'(ready), 0);
        chk_w("arst_done_outR", outR, '0);
        chk_i("arst_done_sub", int'(sub), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset at cycle 10 of an operation.
        do_start(tv[2].c, tv[2].p);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("arst_mid_ready", int'(ready), 0);
        chk_w("arst_mid_outR", outR, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1;
        end
        chk_i("arst_stays_idle", seen, 0);

        do_start(tv[3].c, tv[3].p);
        wait_ready(cyc);
        chk_i("recover_latency", cyc, 17);
        chk_w("recover_outR", outR, tv[3].r);
        chk_i("recover_sub", int'(sub), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
